// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - two-approach intersection phase sequencer
//
// Purpose: steps NS/EW approaches through green, yellow and all-red phases
// on active ticks (en & tick). It guarantees the two approaches are never
// non-red at the same time, and serves latched pedestrian requests with a
// walk window at the start of the matching green.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          run enable; 0 freezes timing, requests still latch
//   tick        one-cycle timebase strobe
//   ped_req_ns  crossing request served during NS green
//   ped_req_ew  crossing request served during EW green
//   light_ns    NS light code (00 idle, 01 red, 10 green, 11 yellow)
//   light_ew    EW light code
//   countdown   ticks remaining in the current phase
//   walk_ns     NS walk signal
//   walk_ew     EW walk signal
//   phase_adv   one-cycle pulse after every phase change
//   phase       current phase code
module intersection_scheduler #(
    parameter int WIDTH    = 5,
    parameter int T_GREEN  = 15,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             ped_req_ns,
    input  logic             ped_req_ew,
    output logic [1:0]       light_ns,
    output logic [1:0]       light_ew,
    output logic [WIDTH-1:0] countdown,
    output logic             walk_ns,
    output logic             walk_ew,
    output logic             phase_adv,
    output logic [2:0]       phase
);

    localparam logic [2:0] PH_IDLE      = 3'd0;
    localparam logic [2:0] PH_NS_GREEN  = 3'd1;
    localparam logic [2:0] PH_NS_YELLOW = 3'd2;
    localparam logic [2:0] PH_CLR_1     = 3'd3;
    localparam logic [2:0] PH_EW_GREEN  = 3'd4;
    localparam logic [2:0] PH_EW_YELLOW = 3'd5;
    localparam logic [2:0] PH_CLR_2     = 3'd6;

    localparam logic [1:0] L_RED    = 2'b01;
    localparam logic [1:0] L_GREEN  = 2'b10;
    localparam logic [1:0] L_YELLOW = 2'b11;

    localparam logic [WIDTH-1:0] CD_ZERO   = '0;
    localparam logic [WIDTH-1:0] CD_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] CD_GREEN  = WIDTH'(T_GREEN);
    localparam logic [WIDTH-1:0] CD_YELLOW = WIDTH'(T_YELLOW);
    localparam logic [WIDTH-1:0] CD_ALLRED = WIDTH'(T_ALLRED);
    // Walk stays on while countdown is strictly above this value.
    localparam logic [WIDTH-1:0] WALK_THR  = WIDTH'(T_GREEN - T_WALK);

    logic             latch_ns;
    logic             latch_ew;

    logic             active;
    logic [2:0]       phase_n;
    logic [WIDTH-1:0] cd_n;
    logic             adv_n;

    logic [1:0]       light_ns_n;
    logic [1:0]       light_ew_n;
    logic             walk_ns_n;
    logic             walk_ew_n;
    logic             latch_ns_n;
    logic             latch_ew_n;
    logic             enter_ns;
    logic             enter_ew;

    assign active = en & tick;

    // State register: every output is registered so phase, countdown and
    // lights always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= PH_IDLE;
            countdown <= CD_ZERO;
            light_ns  <= L_RED;
            light_ew  <= L_RED;
            walk_ns   <= 1'b0;
            walk_ew   <= 1'b0;
            phase_adv <= 1'b0;
            latch_ns  <= 1'b0;
            latch_ew  <= 1'b0;
        end else begin
            phase     <= phase_n;
            countdown <= cd_n;
            light_ns  <= light_ns_n;
            light_ew  <= light_ew_n;
            walk_ns   <= walk_ns_n;
            walk_ew   <= walk_ew_n;
            phase_adv <= adv_n;
            latch_ns  <= latch_ns_n;
            latch_ew  <= latch_ew_n;
        end
    end

    // Next-state logic: phase and countdown.
    always_comb begin
        phase_n = phase;
        cd_n    = countdown;
        adv_n   = 1'b0;
        if (phase > PH_CLR_2) begin
            // Unreachable codes recover through an all-red clearance so
            // neither approach can be handed green without one.
            phase_n = PH_CLR_2;
            cd_n    = CD_ALLRED;
            adv_n   = 1'b1;
        end else if (active) begin
            if (phase == PH_IDLE) begin
                phase_n = PH_NS_GREEN;
                cd_n    = CD_GREEN;
                adv_n   = 1'b1;
            end else if (countdown > CD_ONE) begin
                cd_n = countdown - CD_ONE;
            end else begin
                adv_n = 1'b1;
                case (phase)
                    PH_NS_GREEN:  begin phase_n = PH_NS_YELLOW; cd_n = CD_YELLOW; end
                    PH_NS_YELLOW: begin phase_n = PH_CLR_1;     cd_n = CD_ALLRED; end
                    PH_CLR_1:     begin phase_n = PH_EW_GREEN;  cd_n = CD_GREEN;  end
                    PH_EW_GREEN:  begin phase_n = PH_EW_YELLOW; cd_n = CD_YELLOW; end
                    PH_EW_YELLOW: begin phase_n = PH_CLR_2;     cd_n = CD_ALLRED; end
                    default:      begin phase_n = PH_NS_GREEN;  cd_n = CD_GREEN;  end
                endcase
            end
        end
    end

    // Output logic: values loaded into the output registers, derived from
    // the next phase so lights never lag the phase code.
    always_comb begin
        light_ns_n = L_RED;
        light_ew_n = L_RED;
        case (phase_n)
            PH_NS_GREEN:  light_ns_n = L_GREEN;
            PH_NS_YELLOW: light_ns_n = L_YELLOW;
            PH_EW_GREEN:  light_ew_n = L_GREEN;
            PH_EW_YELLOW: light_ew_n = L_YELLOW;
            default: begin
                light_ns_n = L_RED;
                light_ew_n = L_RED;
            end
        endcase

        enter_ns = adv_n && (phase_n == PH_NS_GREEN);
        enter_ew = adv_n && (phase_n == PH_EW_GREEN);

        // A request present in the entry cycle is served immediately, so
        // the latch is cleared rather than set on that edge.
        latch_ns_n = enter_ns ? 1'b0 : (latch_ns | ped_req_ns);
        latch_ew_n = enter_ew ? 1'b0 : (latch_ew | ped_req_ew);

        // Walk can only start on green entry; afterwards it only holds or
        // drops, so a mid-green request waits for the next green.
        if (enter_ns) begin
            walk_ns_n = latch_ns | ped_req_ns;
        end else if (phase_n == PH_NS_GREEN) begin
            walk_ns_n = walk_ns && (cd_n > WALK_THR);
        end else begin
            walk_ns_n = 1'b0;
        end

        if (enter_ew) begin
            walk_ew_n = latch_ew | ped_req_ew;
        end else if (phase_n == PH_EW_GREEN) begin
            walk_ew_n = walk_ew && (cd_n > WALK_THR);
        end else begin
            walk_ew_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - self-checking bench for intersection_scheduler
module tb_intersection_scheduler;

    localparam int TG = 15;
    localparam int TY = 3;
    localparam int TA = 2;
    localparam int TW = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req_ns = 1'b0;
    logic       ped_req_ew = 1'b0;
    logic [1:0] light_ns;
    logic [1:0] light_ew;
    logic [4:0] countdown;
    logic       walk_ns;
    logic       walk_ew;
    logic       phase_adv;
    logic [2:0] phase;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .WIDTH(5), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .light_ns(light_ns), .light_ew(light_ew), .countdown(countdown),
        .walk_ns(walk_ns), .walk_ew(walk_ew), .phase_adv(phase_adv),
        .phase(phase)
    );

    typedef struct {
        int ph; int cd; int ln; int le; int wn; int we; int adv;
    } exp_t;

    typedef struct {
        bit r; bit e; bit t; bit pn; bit pe;
        exp_t x;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_ph, m_cd;
    bit m_lns, m_lew, m_sn, m_se, m_adv;

    int t_phase, t_cd, t_adv;

    function automatic int dur(int ph);
        case (ph)
            1, 4:    return TG;
            2, 5:    return TY;
            3, 6:    return TA;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_step(bit r, bit e, bit t, bit pn, bit pe, output exp_t x);
        bit changed;
        changed = 1'b0;
        if (r) begin
            m_ph = 0; m_cd = 0;
            m_lns = 0; m_lew = 0; m_sn = 0; m_se = 0; m_adv = 0;
        end else begin
            m_lns = m_lns | pn;
            m_lew = m_lew | pe;
            if (e && t) begin
                if (m_ph == 0) begin
                    m_ph = 1; m_cd = TG; changed = 1'b1;
                end else if (m_cd > 1) begin
                    m_cd = m_cd - 1;
                end else begin
                    m_ph = (m_ph == 6) ? 1 : m_ph + 1;
                    m_cd = dur(m_ph);
                    changed = 1'b1;
                end
            end
            if (changed && m_ph == 1) begin m_sn = m_lns; m_lns = 0; end
            if (changed && m_ph == 4) begin m_se = m_lew; m_lew = 0; end
            if (m_ph != 1) m_sn = 0;
            if (m_ph != 4) m_se = 0;
            m_adv = changed;
        end
        x.ph = m_ph;
        x.cd = m_cd;
        x.ln = (m_ph == 1) ? 2 : (m_ph == 2) ? 3 : 1;
        x.le = (m_ph == 4) ? 2 : (m_ph == 5) ? 3 : 1;
        x.wn = (m_ph == 1 && m_sn && m_cd > TG - TW) ? 1 : 0;
        x.we = (m_ph == 4 && m_se && m_cd > TG - TW) ? 1 : 0;
        x.adv = m_adv ? 1 : 0;
    endtask

    // One clock: drive inputs, queue the expectation, compare after the edge.
    task automatic clk_step(bit r, bit e, bit t, bit pn, bit pe, bit use_tab, exp_t tab);
        exp_t m;
        exp_t x;
        rst = r; en = e; tick = t; ped_req_ns = pn; ped_req_ew = pe;
        model_step(r, e, t, pn, pe, m);
        if (use_tab) sb_q.push_back(tab);
        else         sb_q.push_back(m);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk("sb_phase", int'(phase), x.ph);
        chk("sb_countdown", int'(countdown), x.cd);
        chk("sb_light_ns", int'(light_ns), x.ln);
        chk("sb_light_ew", int'(light_ew), x.le);
        chk("sb_walk_ns", int'(walk_ns), x.wn);
        chk("sb_walk_ew", int'(walk_ew), x.we);
        chk("sb_phase_adv", int'(phase_adv), x.adv);
        chk("safety_one_red", int'(light_ns == 2'b01 || light_ew == 2'b01), 1);
    endtask

    task automatic step(bit r, bit e, bit t, bit pn, bit pe);
        exp_t d;
        d = '{default: 0};
        clk_step(r, e, t, pn, pe, 1'b0, d);
    endtask

    // Tick on the first of four clocks; snapshot outputs right after the tick.
    task automatic tick4(bit e, bit pn, bit pe);
        step(1'b0, e, 1'b1, pn, pe);
        t_phase = int'(phase);
        t_cd    = int'(countdown);
        t_adv   = int'(phase_adv);
        repeat (3) step(1'b0, e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_state(int ph, int cd, int budget);
        int n;
        n = 0;
        while (!(int'(phase) == ph && int'(countdown) == cd) && n < budget) begin
            tick4(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!(int'(phase) == ph && int'(countdown) == cd)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_phase%0d_cd%0d: timed out at phase %0d countdown %0d",
                     ph, cd, phase, countdown);
        end
    endtask

    vec_t tab[8];
    int   dw[$];
    int   exp_dw[6];
    int   cnt;
    int   prev_ph, prev_cd, ycnt;
    bit   ydone;

    initial begin
        tab[0] = '{1, 0, 0, 0, 0, '{0, 0, 1, 1, 0, 0, 0}};
        tab[1] = '{1, 1, 1, 1, 1, '{0, 0, 1, 1, 0, 0, 0}};
        tab[2] = '{0, 0, 1, 1, 0, '{0, 0, 1, 1, 0, 0, 0}};
        tab[3] = '{0, 1, 0, 0, 0, '{0, 0, 1, 1, 0, 0, 0}};
        tab[4] = '{0, 1, 1, 0, 0, '{1, 15, 2, 1, 1, 0, 1}};
        tab[5] = '{0, 1, 0, 0, 0, '{1, 15, 2, 1, 1, 0, 0}};
        tab[6] = '{0, 1, 1, 0, 0, '{1, 14, 2, 1, 1, 0, 0}};
        tab[7] = '{0, 0, 1, 0, 0, '{1, 14, 2, 1, 1, 0, 0}};
        exp_dw = '{15, 3, 2, 15, 3, 2};

        // Reset, idle, latched request while disabled, entry, en freeze.
        for (int i = 0; i < 8; i++)
            clk_step(tab[i].r, tab[i].e, tab[i].t, tab[i].pn, tab[i].pe, 1'b1, tab[i].x);

        // Full cycle with a tick every four clocks.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick4(1'b1, 1'b0, 1'b0);
        chk("t1_entry_phase", t_phase, 1);
        chk("t1_entry_countdown", t_cd, TG);
        chk("t1_entry_adv", t_adv, 1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick4(1'b1, 1'b0, 1'b0);
            cnt++;
            if (t_adv == 1) begin
                dw.push_back(cnt);
                cnt = 0;
            end
        end
        chk("t1_dwell_count", dw.size(), 6);
        for (int i = 0; i < 6 && i < dw.size(); i++)
            chk("t1_dwell", dw[i], exp_dw[i]);
        chk("t1_wrap_phase", int'(phase), 1);
        chk("t1_wrap_countdown", int'(countdown), TG);

        // Enable dropped for 20 ticks at countdown 10.
        wait_state(1, 10, 20);
        repeat (20) tick4(1'b0, 1'b0, 1'b0);
        chk("t2_hold_phase", int'(phase), 1);
        chk("t2_hold_countdown", int'(countdown), 10);
        tick4(1'b1, 1'b0, 1'b0);
        chk("t2_resume_countdown", int'(countdown), 9);

        // EW request during NS yellow.
        wait_state(2, 3, 40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_state(4, 15, 20);
        chk("t3_walk_ew_entry", int'(walk_ew), 1);
        wait_state(4, 9, 20);
        chk("t3_walk_ew_cd9", int'(walk_ew), 1);
        tick4(1'b1, 1'b0, 1'b0);
        chk("t3_cd8", int'(countdown), 8);
        chk("t3_walk_ew_cd8", int'(walk_ew), 0);
        wait_state(4, 15, 60);
        chk("t3_next_green_no_walk", int'(walk_ew), 0);

        // NS request in the entry cycle, then again mid-green.
        wait_state(6, 1, 40);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_entry_phase", int'(phase), 1);
        chk("t4_entry_walk_ns", int'(walk_ns), 1);
        chk("t4_entry_adv", int'(phase_adv), 1);
        wait_state(1, 12, 20);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_walk_ns_cd12", int'(walk_ns), 1);
        wait_state(1, 8, 20);
        chk("t4_walk_ns_cd8", int'(walk_ns), 0);
        wait_state(1, 15, 60);
        chk("t4_next_green_walk_ns", int'(walk_ns), 1);

        // Reset during EW yellow with both requests pending.
        wait_state(5, 2, 60);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_phase", int'(phase), 0);
        chk("t5_light_ns", int'(light_ns), 1);
        chk("t5_light_ew", int'(light_ew), 1);
        chk("t5_countdown", int'(countdown), 0);
        chk("t5_walk_ns", int'(walk_ns), 0);
        chk("t5_walk_ew", int'(walk_ew), 0);
        chk("t5_phase_adv", int'(phase_adv), 0);
        tick4(1'b1, 1'b0, 1'b0);
        chk("t5_restart_phase", t_phase, 1);
        chk("t5_latch_ns_cleared", int'(walk_ns), 0);
        wait_state(4, 15, 30);
        chk("t5_latch_ew_cleared", int'(walk_ew), 0);

        // Tick held high: one advance per clock.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        prev_ph = 0; prev_cd = 0; ycnt = 0; ydone = 1'b0;
        for (int c = 0; c < 45; c++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (int'(phase) != prev_ph) begin
                chk("t6_order", int'(phase), (prev_ph == 0 || prev_ph == 6) ? 1 : prev_ph + 1);
                if (prev_ph == 2 && !ydone) begin
                    chk("t6_yellow_cycles", ycnt, TY);
                    ydone = 1'b1;
                end
            end else begin
                chk("t6_decrement", int'(countdown), prev_cd - 1);
            end
            if (int'(phase) == 2) ycnt++;
            prev_ph = int'(phase);
            prev_cd = int'(countdown);
        end
        chk("t6_yellow_seen", int'(ydone), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
